// File: rtl/acc_ctrl.sv
// Accumulator control micro-sequencer: expands LOAD/ALU/STORE/ALU_STORE commands
// into single-cycle strobe steps, with strobes re-timed to the falling clock edge.
module acc_ctrl #(
  parameter int                      OPCODE_WIDTH = 5,
  parameter int                      STATUS_WIDTH = 4,
  parameter logic [OPCODE_WIDTH-1:0] LD_OPCODE    = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_type,
  input  logic [OPCODE_WIDTH-1:0] cmd_opcode,
  output logic                    done,
  output logic                    acc_CS,
  output logic                    acc_WE,
  output logic                    acc_OE,
  output logic                    acc_ALU_EN,
  output logic [OPCODE_WIDTH-1:0] alu_opcode,
  input  logic [STATUS_WIDTH-1:0] alu_status,
  output logic [STATUS_WIDTH-1:0] flags,
  output logic                    src_OE,
  output logic                    dst_WE
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EXEC,
    S_STORE,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    CMD_LOAD      = 2'b00,
    CMD_ALU       = 2'b01,
    CMD_STORE     = 2'b10,
    CMD_ALU_STORE = 2'b11
  } cmd_t;

  state_t                  state_q, state_d;
  cmd_t                    type_q, type_d;
  logic [OPCODE_WIDTH-1:0] opc_q, opc_d;
  logic [STATUS_WIDTH-1:0] flags_q, flags_d;

  logic                    cs_d, we_d, oe_d, alu_en_d, src_oe_d, dst_we_d;
  logic [OPCODE_WIDTH-1:0] aluop_d;
  logic                    cs_q, we_q, oe_q, alu_en_q, src_oe_q, dst_we_q;
  logic [OPCODE_WIDTH-1:0] aluop_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      type_q  <= CMD_LOAD;
      opc_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      opc_q   <= opc_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    opc_d   = opc_q;
    flags_d = flags_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          type_d = cmd_t'(cmd_type);
          opc_d  = cmd_opcode;
          case (cmd_t'(cmd_type))
            CMD_LOAD:      state_d = S_LOAD;
            CMD_ALU:       state_d = S_EXEC;
            CMD_STORE:     state_d = S_STORE;
            CMD_ALU_STORE: state_d = S_EXEC;
            default:       state_d = S_IDLE;
          endcase
        end
      end
      S_LOAD:  state_d = S_DONE;
      S_EXEC: begin
        flags_d = alu_status;
        state_d = (type_q == CMD_ALU_STORE) ? S_STORE : S_DONE;
      end
      S_STORE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cs_d     = 1'b0;
    we_d     = 1'b0;
    oe_d     = 1'b0;
    alu_en_d = 1'b0;
    src_oe_d = 1'b0;
    dst_we_d = 1'b0;
    aluop_d  = LD_OPCODE;
    case (state_q)
      S_LOAD: begin
        cs_d     = 1'b1;
        we_d     = 1'b1;
        src_oe_d = 1'b1;
      end
      S_EXEC: begin
        alu_en_d = 1'b1;
        aluop_d  = opc_q;
      end
      S_STORE: begin
        cs_d     = 1'b1;
        oe_d     = 1'b1;
        dst_we_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Falling-edge retiming keeps strobes stable while clk is high, so the
  // accumulator's gated clock sees exactly one capture edge per step.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      cs_q     <= 1'b0;
      we_q     <= 1'b0;
      oe_q     <= 1'b0;
      alu_en_q <= 1'b0;
      src_oe_q <= 1'b0;
      dst_we_q <= 1'b0;
      aluop_q  <= LD_OPCODE;
    end else begin
      cs_q     <= cs_d;
      we_q     <= we_d;
      oe_q     <= oe_d;
      alu_en_q <= alu_en_d;
      src_oe_q <= src_oe_d;
      dst_we_q <= dst_we_d;
      aluop_q  <= aluop_d;
    end
  end

  assign cmd_ready  = reset & (state_q == S_IDLE);
  assign done       = (state_q == S_DONE);
  assign flags      = flags_q;
  assign acc_CS     = cs_q;
  assign acc_WE     = we_q;
  assign acc_OE     = oe_q;
  assign acc_ALU_EN = alu_en_q;
  assign src_OE     = src_oe_q;
  assign dst_WE     = dst_we_q;
  assign alu_opcode = aluop_q;

endmodule
